// File: rtl/rvco_meas_pkg.sv
// Shared types and defaults for the ring-VCO measurement sequencer.
package rvco_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_SETTLE,
        ST_GATE,
        ST_DONE
    } meas_state_t;

    localparam logic [1:0] SEL_OSC0 = 2'b01;
    localparam logic [1:0] SEL_OSC1 = 2'b10;
    localparam logic [1:0] SEL_BOTH = 2'b11;

    localparam int DEF_CNT_W         = 12;
    localparam int DEF_GATE_CYCLES   = 1024;
    localparam int DEF_RST_CYCLES    = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/rvco_edge_sync.sv
// Multi-flop synchronizer for one raw oscillator output plus a rising-edge detector.
module rvco_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // raw feeds only sync_q[0]; everything downstream sees the settled copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rvco_measure_sequencer.sv
// Reset/settle/gate sequencer with one shared edge counter for the two ring VCOs.
// Define RVCO_CONT_MEAS_EN to repeat the latched selection continuously instead of single-shot.
module rvco_measure_sequencer
    import rvco_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       sel,
    input  logic [1:0]       osc_out,
    output logic [1:0]       osc_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [1:0]       ovf
);

    localparam int MAX_A   = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

    meas_state_t      state;
    logic             cur;
    logic [1:0]       sel_q;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_run;
    logic [1:0]       rise;
    logic             edge_cur;
    logic             cnt_full;
    logic             drop;

    rvco_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (osc_out[0]),
        .rise (rise[0])
    );

    rvco_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (osc_out[1]),
        .rise (rise[1])
    );

    // The counter saturates; an edge arriving at full scale is lost and flagged
    assign edge_cur = cur ? rise[1] : rise[0];
    assign cnt_full = (cnt == {CNT_W{1'b1}});
    assign drop     = edge_cur & cnt_full;
    assign cnt_next = (edge_cur && !cnt_full) ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cur     <= 1'b0;
            sel_q   <= 2'b00;
            timer   <= '0;
            cnt     <= '0;
            ovf_run <= 1'b0;
            osc_rst <= 2'b11;
            busy    <= 1'b0;
            done    <= 1'b0;
            count0  <= '0;
            count1  <= '0;
            ovf     <= 2'b00;
        end else if (abort) begin
            state   <= ST_IDLE;
            osc_rst <= 2'b11;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    osc_rst <= 2'b11;
                    if (start && sel != 2'b00) begin
                        sel_q <= sel;
                        cur   <= (sel == SEL_OSC1);
                        timer <= RST_LOAD;
                        busy  <= 1'b1;
                        state <= ST_RESET;
                        if (sel[0]) begin
                            count0 <= '0;
                            ovf[0] <= 1'b0;
                        end
                        if (sel[1]) begin
                            count1 <= '0;
                            ovf[1] <= 1'b0;
                        end
                    end
                end
                ST_RESET: begin
                    osc_rst <= 2'b11;
                    if (timer == '0) begin
                        osc_rst <= cur ? 2'b01 : 2'b10;
                        timer   <= SETTLE_LOAD;
                        state   <= ST_SETTLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                // Settling is long enough to flush stale synchronizer history
                ST_SETTLE: begin
                    if (timer == '0) begin
                        cnt     <= '0;
                        ovf_run <= 1'b0;
                        timer   <= GATE_LOAD;
                        state   <= ST_GATE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    cnt     <= cnt_next;
                    ovf_run <= ovf_run | drop;
                    if (timer == '0) begin
                        if (cur) begin
                            count1 <= cnt_next;
                            ovf[1] <= ovf_run | drop;
                        end else begin
                            count0 <= cnt_next;
                            ovf[0] <= ovf_run | drop;
                        end
                        osc_rst <= 2'b11;
                        if (sel_q == SEL_BOTH && !cur) begin
                            cur   <= 1'b1;
                            timer <= RST_LOAD;
                            state <= ST_RESET;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
`ifdef RVCO_CONT_MEAS_EN
                    cur   <= (sel_q == SEL_OSC1);
                    timer <= RST_LOAD;
                    state <= ST_RESET;
`else
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`endif
                end
                default: begin
                    osc_rst <= 2'b11;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvco_measure_sequencer.sv
// Scoreboard bench for rvco_measure_sequencer; expected results are queued at start and checked at done.
module tb_rvco_measure_sequencer;
    import rvco_meas_pkg::*;

    localparam int CNT_W    = 8;
    localparam int GATE     = 100;
    localparam int RSTC     = 4;
    localparam int SETTLE   = 8;
    localparam int SYNC     = 2;
    localparam int GATE_OVF = 600;
    localparam int LAT1     = RSTC + SETTLE + GATE + 1;
    localparam int LAT2     = 2 * (RSTC + SETTLE + GATE) + 1;
    localparam int LAT_OVF  = RSTC + SETTLE + GATE_OVF + 1;
    localparam int MAX_WAIT = 2000;

    typedef struct {
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c1;
        logic [1:0]       ovf;
        int               lat;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0] sel = 2'b00;
    logic osc_a = 1'b0;
    logic osc_b = 1'b0;
    logic osc_fast = 1'b0;
    logic [1:0] osc_out;
    logic [1:0] osc_rst;
    logic busy;
    logic done;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;
    logic [1:0] ovf;

    logic start2 = 1'b0;
    logic abort2 = 1'b0;
    logic [1:0] sel2 = 2'b00;
    logic [1:0] osc_out2;
    logic [1:0] osc_rst2;
    logic busy2;
    logic done2;
    logic [CNT_W-1:0] count0_2;
    logic [CNT_W-1:0] count1_2;
    logic [1:0] ovf2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [1:0] osc_hist [0:MAX_WAIT];

    assign osc_out  = {osc_b, osc_a};
    assign osc_out2 = {osc_fast, 1'b0};

    // Oscillator edges land on clk falling edges so sampling is unambiguous
    always #5 clk = ~clk;
    always #20 osc_a = ~osc_a;
    always #50 osc_b = ~osc_b;
    always #10 osc_fast = ~osc_fast;
    always @(posedge clk) cyc <= cyc + 1;

    rvco_measure_sequencer #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .RST_CYCLES(RSTC),
        .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
        .osc_out(osc_out), .osc_rst(osc_rst), .busy(busy), .done(done),
        .count0(count0), .count1(count1), .ovf(ovf)
    );

    rvco_measure_sequencer #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE_OVF), .RST_CYCLES(RSTC),
        .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut_ovf (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .sel(sel2),
        .osc_out(osc_out2), .osc_rst(osc_rst2), .busy(busy2), .done(done2),
        .count0(count0_2), .count1(count1_2), .ovf(ovf2)
    );

    task automatic do_start(input logic [1:0] s, output int t0);
        @(negedge clk);
        sel = s;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        int k;
        lat = -1;
        for (int i = 0; i < MAX_WAIT && lat < 0; i++) begin
            k = cyc - t0;
            if (k >= 0 && k <= MAX_WAIT) osc_hist[k] = osc_rst;
            if (done === 1'b1) lat = k;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (osc_rst !== 2'b11 || busy !== 1'b0 || done !== 1'b0 || count0 !== '0 ||
            count1 !== '0 || ovf !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_values got osc_rst=%b busy=%b done=%b c0=%0d c1=%0d ovf=%b want 11 0 0 0 0 00",
                     osc_rst, busy, done, count0, count1, ovf);
        end
        checks++;
        if (osc_rst2 !== 2'b11 || busy2 !== 1'b0 || count1_2 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values_ovf got osc_rst=%b busy=%b c1=%0d want 11 0 0",
                     osc_rst2, busy2, count1_2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        int t0, lat, bad_k;
        logic [1:0] want, bad_got, bad_want;
        e.c0 = 8'd25; e.c1 = 8'd0; e.ovf = 2'b00; e.lat = LAT1;
        sb.push_back(e);
        do_start(SEL_OSC0, t0);
        wait_done(t0, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL single_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (count0 !== e.c0 || ovf !== e.ovf) begin
            errors++;
            $display("[TB] FAIL single_result got c0=%0d ovf=%b want c0=%0d ovf=%b", count0, ovf, e.c0, e.ovf);
        end
        bad_k = -1;
        bad_got = 2'b00;
        bad_want = 2'b00;
        for (int k = 1; k <= LAT1; k++) begin
            want = (k > RSTC && k <= RSTC + SETTLE + GATE) ? 2'b10 : 2'b11;
            if (bad_k < 0 && osc_hist[k] !== want) begin
                bad_k = k;
                bad_got = osc_hist[k];
                bad_want = want;
            end
        end
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("[TB] FAIL single_osc_rst_seq cycle %0d got %b want %b", bad_k, bad_got, bad_want);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_after_done got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_both();
        exp_t e;
        int t0, lat, bad_k;
        e.c0 = 8'd25; e.c1 = 8'd10; e.ovf = 2'b00; e.lat = LAT2;
        sb.push_back(e);
        do_start(SEL_BOTH, t0);
        wait_done(t0, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL both_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (count0 !== e.c0 || count1 !== e.c1 || ovf !== e.ovf) begin
            errors++;
            $display("[TB] FAIL both_result got c0=%0d c1=%0d ovf=%b want c0=%0d c1=%0d ovf=%b",
                     count0, count1, ovf, e.c0, e.c1, e.ovf);
        end
        bad_k = -1;
        for (int k = 1; k <= LAT2; k++)
            if (bad_k < 0 && osc_hist[k] === 2'b00) bad_k = k;
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("[TB] FAIL both_osc_rst_00 got 00 at cycle %0d want never 00", bad_k);
        end
        checks++;
        if (osc_hist[200] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL both_osc1_running got %b want 01", osc_hist[200]);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int t0, lat;
        e.c0 = 8'd0; e.c1 = 8'd255; e.ovf = 2'b10; e.lat = LAT_OVF;
        sb.push_back(e);
        @(negedge clk);
        sel2 = SEL_OSC1;
        start2 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        lat = -1;
        for (int i = 0; i < MAX_WAIT && lat < 0; i++) begin
            if (done2 === 1'b1) lat = cyc - t0;
            else @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL ovf_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (count1_2 !== e.c1 || ovf2 !== e.ovf || count0_2 !== e.c0) begin
            errors++;
            $display("[TB] FAIL ovf_result got c0=%0d c1=%0d ovf=%b want c0=%0d c1=%0d ovf=%b",
                     count0_2, count1_2, ovf2, e.c0, e.c1, e.ovf);
        end
    endtask

    task automatic test_start_busy();
        exp_t e;
        int t0, lat;
        e.c0 = 8'd25; e.c1 = 8'd10; e.ovf = 2'b00; e.lat = LAT1;
        sb.push_back(e);
        do_start(SEL_OSC0, t0);
        repeat (40) @(negedge clk);
        sel = SEL_BOTH;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_start_busy got %b want 1", busy);
        end
        wait_done(t0, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || count0 !== e.c0 || count1 !== e.c1) begin
            errors++;
            $display("[TB] FAIL busy_start_result got lat=%0d c0=%0d c1=%0d want lat=%0d c0=%0d c1=%0d",
                     lat, count0, count1, e.lat, e.c0, e.c1);
        end
    endtask

    task automatic test_idle_ignored();
        int busy_seen, done_seen;
        @(negedge clk);
        sel = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = 0;
        done_seen = 0;
        repeat (20) begin
            if (busy !== 1'b0) busy_seen++;
            if (done !== 1'b0) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0 || done_seen != 0) begin
            errors++;
            $display("[TB] FAIL sel00_ignored got busy_cycles=%0d done_cycles=%0d want 0 0", busy_seen, done_seen);
        end
        sel = SEL_BOTH;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        busy_seen = 0;
        repeat (20) begin
            if (busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0 || count0 !== 8'd25 || count1 !== 8'd10) begin
            errors++;
            $display("[TB] FAIL start_abort_idle got busy_cycles=%0d c0=%0d c1=%0d want 0 25 10",
                     busy_seen, count0, count1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int t0, lat;
        do_start(SEL_OSC0, t0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (osc_rst !== 2'b11 || busy !== 1'b0 || done !== 1'b0 || count0 !== '0 ||
            count1 !== '0 || ovf !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid got osc_rst=%b busy=%b done=%b c0=%0d c1=%0d ovf=%b want 11 0 0 0 0 00",
                     osc_rst, busy, done, count0, count1, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e.c0 = 8'd25; e.c1 = 8'd0; e.ovf = 2'b00; e.lat = LAT1;
        sb.push_back(e);
        do_start(SEL_OSC0, t0);
        wait_done(t0, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || count0 !== e.c0 || count1 !== e.c1) begin
            errors++;
            $display("[TB] FAIL reset_mid_rerun got lat=%0d c0=%0d c1=%0d want lat=%0d c0=%0d c1=%0d",
                     lat, count0, count1, e.lat, e.c0, e.c1);
        end
    endtask

    task automatic test_abort();
        int t0, done_seen;
        do_start(SEL_BOTH, t0);
        repeat (59) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || osc_rst !== 2'b11 || count0 !== '0 || count1 !== '0) begin
            errors++;
            $display("[TB] FAIL abort_state got busy=%b osc_rst=%b c0=%0d c1=%0d want 0 11 0 0",
                     busy, osc_rst, count0, count1);
        end
        done_seen = 0;
        repeat (300) begin
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen != 0 || count0 !== '0 || count1 !== '0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got active_cycles=%0d c0=%0d c1=%0d want 0 0 0",
                     done_seen, count0, count1);
        end
    endtask

    task automatic test_continuous();
        exp_t e;
        int t0, lat;
        for (int r = 0; r < 3; r++) begin
            e.c0 = 8'd25; e.c1 = 8'd0; e.ovf = 2'b00; e.lat = LAT1;
            sb.push_back(e);
        end
        do_start(SEL_OSC0, t0);
        for (int r = 0; r < 3; r++) begin
            wait_done(t0, lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || count0 !== e.c0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cont_run%0d got lat=%0d c0=%0d busy=%b want lat=%0d c0=%0d busy=1",
                         r, lat, count0, busy, e.lat, e.c0);
            end
            t0 = cyc;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || osc_rst !== 2'b11) begin
            errors++;
            $display("[TB] FAIL cont_abort got busy=%b osc_rst=%b want 0 11", busy, osc_rst);
        end
    endtask

    initial begin
        test_reset();
`ifdef RVCO_CONT_MEAS_EN
        test_continuous();
`else
        test_single();
        test_both();
        test_overflow();
        test_start_busy();
        test_idle_ignored();
        test_reset_mid();
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvco_measure_sequencer.md
Name: rvco_measure_sequencer

Overview:
- Digital controller for the two on-chip 11-stage ring VCOs.
- Sequences each oscillator through reset, release/settle and a fixed gate window, then counts output edges in the window and reports a per-oscillator frequency count.
- Time-shares one counter between the two oscillators. The idle oscillator is held in reset to avoid injection-locking and supply coupling.
- Sits between the digital pins and the analog macro: it drives the VCO reset nets and samples the VCO outputs.

Parameters:
- CNT_W, 12, width of edge counter and result registers.
- GATE_CYCLES, 1024, clk cycles in the counting window (>=1).
- RST_CYCLES, 4, clk cycles the selected oscillator is held in reset before release (>=1).
- SETTLE_CYCLES, 16, clk cycles after release before counting starts (>= SYNC_STAGES+1).
- SYNC_STAGES, 2, flops in each oscillator-output synchronizer (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  cancels a run in progress.
- sel  in  2  01 = osc0 only, 10 = osc1 only, 11 = osc0 then osc1, 00 = invalid.
- osc_out  in  2  raw, asynchronous oscillator outputs.
- osc_rst  out  2  active-high oscillator reset (1 = stopped).
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when all selected measurements finish.
- count0  out  CNT_W  last osc0 result.
- count1  out  CNT_W  last osc1 result.
- ovf  out  2  per-oscillator counter saturation flag.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low. All state is reset asynchronously and released synchronously by design intent.
- Reset values: osc_rst=2'b11, busy=0, done=0, count0=0, count1=0, ovf=0, FSM=IDLE, synchronizers=0.
- FSM states: IDLE, RESET, SETTLE, GATE, DONE. A current-oscillator index cur is held alongside the state.
- IDLE:
  - osc_rst=11.
  - start=1 with sel!=00: latch sel, set cur = (sel==10) ? 1 : 0, clear the count/ovf of each selected oscillator, go to RESET.
  - start with sel=00 is ignored.
  - start while busy is ignored, not queued.
- RESET: osc_rst[cur]=1 for RST_CYCLES cycles, then SETTLE.
- SETTLE: osc_rst[cur]=0, other bit stays 1. Lasts SETTLE_CYCLES cycles; synchronizer history is flushed here. Then GATE.
- GATE:
  - osc_rst[cur]=0 for exactly GATE_CYCLES cycles.
  - Counter increments on each synchronized 0->1 transition of osc_out[cur].
  - Counter saturates at 2^CNT_W-1 and sets ovf[cur].
  - On the last gate cycle, write the result to count[cur] and set osc_rst[cur]=1 on the next cycle.
  - If latched sel==11 and cur==0: set cur=1 and go to RESET. Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start accept to done pulse = RST_CYCLES+SETTLE_CYCLES+GATE_CYCLES+1 cycles for a single oscillator, 2*(RST+SETTLE+GATE)+1 for sel=11.
- abort: has priority over every state transition. Next state is IDLE, osc_rst=11, no done pulse, and count registers of the aborted run remain cleared.
- Simultaneous start+abort in IDLE: abort wins, start is dropped.
- Reset mid-run: immediate return to reset values; both oscillators are stopped.
- Only synchronized osc_out is used; raw osc_out never reaches logic other than the first flop.

Optional Feature:
- Macro: RVCO_CONT_MEAS_EN.
- Defined: after DONE the FSM returns to RESET with the same latched sel instead of IDLE. Results refresh every run and done pulses each run. busy stays 1 until abort or reset; start is ignored while running.
- Undefined: single-shot operation as above.

Decomposition:
- Package rvco_meas_pkg holds: the FSM state enum, the sel encodings (SEL_OSC0, SEL_OSC1, SEL_BOTH), and default parameter constants.
- One sub-module, rvco_edge_sync: an SYNC_STAGES-deep synchronizer plus rising-edge detector, instanced twice, one per oscillator.

Test Plan:
All cases use CNT_W=8, GATE=100, RST=4, SETTLE=8.
1. sel=01, osc_out[0] = square wave of period 4 clk -> osc_rst sequence 11→11 (4 cycles)→10 (108 cycles)→11; done at cycle 113; count0=25; ovf=00.
2. sel=11, osc0 period 4, osc1 period 10 -> count0=25, count1=10; osc_rst is never 00; done at cycle 225.
3. sel=10, osc1 period 2 with GATE=600 -> count1=255, ovf=10.
4. abort asserted in GATE of the sel=11 run -> IDLE next cycle, osc_rst=11, no done, count0=count1=0.
5. start while busy, start with sel=00, and start+abort in IDLE -> all ignored; busy stays as before.
6. rst_n low mid-SETTLE -> all outputs at reset values asynchronously; a later start runs normally. With RVCO_CONT_MEAS_EN defined, 3 consecutive done pulses occur 113 cycles apart.
